// File: rtl/dht11_bus_controller.sv
// DHT11 single-wire transaction sequencer: host start pulse, response preamble check, 40-bit pulse-width decode.
// Optional build macro DHT_CHECKSUM_EN: reject frames whose checksum byte mismatches the sum of the upper four bytes.
module dht11_bus_controller #(
    parameter int START_LOW_CYCLES = 900000,
    parameter int TIMEOUT_CYCLES   = 5000,
    parameter int BIT_THRESHOLD    = 2000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [39:0] data,
    output logic        dir,
    output logic        send,
    input  logic        read,
    output logic [3:0]  dbg_state
);

    localparam int MAXP = (START_LOW_CYCLES > TIMEOUT_CYCLES)
                        ? ((START_LOW_CYCLES > BIT_THRESHOLD) ? START_LOW_CYCLES : BIT_THRESHOLD)
                        : ((TIMEOUT_CYCLES > BIT_THRESHOLD) ? TIMEOUT_CYCLES : BIT_THRESHOLD);
    localparam int CW = $clog2(MAXP) + 1;

    localparam logic [CW-1:0] START_LAST = CW'(START_LOW_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] THR        = CW'(BIT_THRESHOLD);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        START_LOW = 4'd1,
        RELEASE   = 4'd2,
        RESP_LOW  = 4'd3,
        RESP_HIGH = 4'd4,
        BIT_LOW   = 4'd5,
        BIT_HIGH  = 4'd6,
        DONE      = 4'd7,
        ERROR     = 4'd8
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [5:0]     bit_cnt_q, bit_cnt_d;
    logic [39:0]    shreg_q, shreg_d;
    logic [39:0]    data_q, data_d;
    logic [1:0]     sync_q;
    logic           rs_prev_q;

    logic           rs;
    logic           rs_fell;
    logic           timeout;
    logic [39:0]    frame;
    logic           chk_ok;

    assign rs      = sync_q[1];
    assign rs_fell = rs_prev_q & ~rs;
    assign timeout = (cnt_q == TO_LAST);
    // The cycle in which BIT_LOW saw the rising edge is part of the pulse, so
    // a high of N clocks leaves N-1 in the counter when the falling edge is seen.
    assign frame   = {shreg_q[38:0], (cnt_q >= THR)};

`ifdef DHT_CHECKSUM_EN
    logic [7:0] sum;
    assign sum    = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
    assign chk_ok = (frame[7:0] == sum);
`else
    assign chk_ok = 1'b1;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            sync_q    <= '0;
            rs_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            sync_q    <= {sync_q[0], read};
            rs_prev_q <= rs;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = (state_q == IDLE) ? '0 : cnt_q + CW'(1);
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        data_d    = data_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = START_LOW;
                    bit_cnt_d = '0;
                    shreg_d   = '0;
                end
            end
            START_LOW: begin
                if (cnt_q == START_LAST) state_d = RELEASE;
            end
            // The synchronizer still holds the host's own low pulse here, so
            // only a fresh falling edge counts as the sensor answering.
            RELEASE: begin
                if (rs_fell)      state_d = RESP_LOW;
                else if (timeout) state_d = ERROR;
            end
            RESP_LOW: begin
                if (rs)           state_d = RESP_HIGH;
                else if (timeout) state_d = ERROR;
            end
            RESP_HIGH: begin
                if (!rs)          state_d = BIT_LOW;
                else if (timeout) state_d = ERROR;
            end
            BIT_LOW: begin
                if (rs)           state_d = BIT_HIGH;
                else if (timeout) state_d = ERROR;
            end
            BIT_HIGH: begin
                if (!rs) begin
                    shreg_d   = frame;
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    if (bit_cnt_q == 6'd39) begin
                        if (chk_ok) begin
                            data_d  = frame;
                            state_d = DONE;
                        end else begin
                            state_d = ERROR;
                        end
                    end else begin
                        state_d = BIT_LOW;
                    end
                end else if (timeout) begin
                    state_d = ERROR;
                end
            end
            DONE:    state_d = IDLE;
            ERROR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) cnt_d = '0;
    end

    assign busy      = (state_q != IDLE) && (state_q != DONE) && (state_q != ERROR);
    assign done      = (state_q == DONE);
    assign error     = (state_q == ERROR);
    assign dir       = (state_q == START_LOW);
    assign send      = 1'b0;
    assign data      = data_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dht11_bus_controller.sv
// Directed bench for dht11_bus_controller with an open-drain line and a simple DHT11 sensor model.
module tb_dht11_bus_controller;

    localparam int SLOW = 100;
    localparam int TOUT = 50;
    localparam int THR  = 20;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        busy, done, error, dir, send;
    logic [39:0] data;
    logic        read;
    logic [3:0]  dbg_state;
    logic        sensor_low;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt = 0, err_cnt = 0, dir_hi_cnt = 0;
    int done_cyc = 0, err_cyc = 0, dir_fall_cyc = 0, fall_cyc = 0;
    logic [39:0] done_data = '0;
    logic        prev_dir = 1'b0;

    // Open-drain line with pull-up: low when the host drives or the sensor pulls.
    assign read = (dir | sensor_low) ? 1'b0 : 1'b1;

    dht11_bus_controller #(
        .START_LOW_CYCLES(SLOW),
        .TIMEOUT_CYCLES  (TOUT),
        .BIT_THRESHOLD   (THR)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .data     (data),
        .dir      (dir),
        .send     (send),
        .read     (read),
        .dbg_state(dbg_state)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (done) begin
            done_cnt++;
            done_cyc  = cyc;
            done_data = data;
        end
        if (error) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (dir) dir_hi_cnt++;
        if (prev_dir && !dir) dir_fall_cyc = cyc;
        prev_dir = dir;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [39:0] f, input int hi0, input int hi1, input int nbits);
        repeat (4) @(negedge clock);
        sensor_low = 1'b1;
        repeat (20) @(negedge clock);
        sensor_low = 1'b0;
        repeat (20) @(negedge clock);
        for (int i = 0; i < nbits; i++) begin
            sensor_low = 1'b1;
            repeat (10) @(negedge clock);
            sensor_low = 1'b0;
            repeat (f[39-i] ? hi1 : hi0) @(negedge clock);
        end
        if (nbits == 40) begin
            sensor_low = 1'b1;
            fall_cyc   = cyc;
            repeat (10) @(negedge clock);
            sensor_low = 1'b0;
        end
    endtask

    task automatic run_txn(input string name, input logic [39:0] f, input int hi0, input int hi1,
                           input bit respond, input bit extra_start,
                           input int exp_done, input int exp_err, input logic [39:0] exp_data);
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        dir_hi_cnt = 0;
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        check({name, "_busy_after_start"}, 64'(busy), 64'd1);
        check({name, "_dir_after_start"}, 64'(dir), 64'd1);
        if (extra_start) begin
            @(negedge clock) start = 1'b1;
            @(negedge clock) start = 1'b0;
            check({name, "_busy_during_ignored_start"}, 64'(busy), 64'd1);
        end
        for (int i = 0; i < 400 && dir; i++) @(negedge clock);
        check({name, "_dir_high_cycles"}, 64'(dir_hi_cnt), 64'(SLOW));
        if (respond) send_frame(f, hi0, hi1, 40);
        for (int i = 0; i < 300 && done_cnt == d0 && err_cnt == e0; i++) @(negedge clock);
        repeat (5) @(negedge clock);
        check({name, "_done_pulses"}, 64'(done_cnt - d0), 64'(exp_done));
        check({name, "_error_pulses"}, 64'(err_cnt - e0), 64'(exp_err));
        check({name, "_data"}, 64'(data), 64'(exp_data));
        check({name, "_busy_idle"}, 64'(busy), 64'd0);
        if (exp_done == 1) begin
            check({name, "_done_data"}, 64'(done_data), 64'(exp_data));
            check({name, "_done_latency_3_to_4"},
                  64'((done_cyc - fall_cyc >= 3) && (done_cyc - fall_cyc <= 4)), 64'd1);
        end
        if (exp_err == 1 && !respond)
            check({name, "_error_latency"}, 64'(err_cyc - dir_fall_cyc), 64'(TOUT));
    endtask

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        sensor_low = 1'b0;
        repeat (5) @(negedge clock);
        check("reset_dir", 64'(dir), 64'd0);
        check("reset_send", 64'(send), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_error", 64'(error), 64'd0);
        check("reset_data", 64'(data), 64'd0);
        check("reset_state", 64'(dbg_state), 64'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);

        run_txn("good", 40'h32_00_19_00_4B, 8, 30, 1'b1, 1'b0, 1, 0, 40'h32_00_19_00_4B);

        run_txn("noresp", 40'h0, 8, 30, 1'b0, 1'b0, 0, 1, 40'h32_00_19_00_4B);

`ifdef DHT_CHECKSUM_EN
        run_txn("badsum", 40'h32_00_19_00_00, 8, 30, 1'b1, 1'b0, 0, 1, 40'h32_00_19_00_4B);
`else
        run_txn("badsum", 40'h32_00_19_00_00, 8, 30, 1'b1, 1'b0, 1, 0, 40'h32_00_19_00_00);
`endif

        // Abort during the high phase of bit 12.
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        for (int i = 0; i < 400 && dir; i++) @(negedge clock);
        send_frame(40'hFF_FF_FF_FF_FF, 8, 30, 11);
        sensor_low = 1'b1;
        repeat (10) @(negedge clock);
        sensor_low = 1'b0;
        repeat (5) @(negedge clock);
        check("midrst_busy_before", 64'(busy), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_dir", 64'(dir), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_data", 64'(data), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        run_txn("after_rst", 40'h2D_00_17_00_44, 8, 30, 1'b1, 1'b0, 1, 0, 40'h2D_00_17_00_44);

        // 20-clock highs must decode as 0 and 21-clock highs as 1.
        run_txn("threshold", 40'h32_00_19_00_4B, 20, 21, 1'b1, 1'b1, 1, 0, 40'h32_00_19_00_4B);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
